// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
// Shares the single VGA pixel-write port between the tower, car and
// screen/text drawers. One requester owns the port at a time for a burst of
// up to MAX_BURST pixels; ownership rotates round-robin with one idle cycle
// between owners. Accepted pixels appear on the VGA side one clock later.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req[NREQ]            per-requester pixel valid
//   coord_in[15*NREQ]    slice i = {x[7:0], y[6:0]}
//   colour_in[9*NREQ]    slice i = 9-bit RGB
//   ack[NREQ]            combinational pixel-accepted strobe (grant & req)
//   grant[NREQ]          registered one-hot owner
//   busy                 registered, high while a requester owns the port
//   coordinates, colours registered pixel to the VGA adapter
//   VGA_write_enable     registered pixel write strobe
//
// Optional feature macro: VGA_ARB_CLIP_EN -- when defined, accepted pixels
// outside X_MAX x Y_MAX are acked and counted but not written.
module vga_draw_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned X_MAX     = 160,
  parameter int unsigned Y_MAX     = 120
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req,
  input  logic [15*NREQ-1:0]  coord_in,
  input  logic [9*NREQ-1:0]   colour_in,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic [14:0]         coordinates,
  output logic [8:0]          colours,
  output logic                VGA_write_enable
);

  localparam int unsigned IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW    = 8;
  localparam int unsigned COORD_W = 15;
  localparam int unsigned COL_W   = 9;

  // Elaboration-time guard on parameter ranges the counters and clip compare rely on.
  if (MAX_BURST < 1 || MAX_BURST > 255 || X_MAX > 256 || Y_MAX > 128) begin : g_bad_param
    $error("vga_draw_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [IDXW-1:0]      owner_q, owner_d;
  logic [IDXW-1:0]      rr_q, rr_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [COORD_W-1:0]   coord_q, coord_d;
  logic [COL_W-1:0]     colour_q, colour_d;
  logic                 we_q, we_d;

  logic                 sel_found;
  logic [IDXW-1:0]      sel_idx;
  logic [IDXW-1:0]      cand;
  logic [IDXW-1:0]      next_rr;
  logic [COORD_W-1:0]   own_coord;
  logic [COL_W-1:0]     own_colour;
  logic                 accept;
  logic                 pix_ok;

  assign own_coord  = coord_in[COORD_W*owner_q +: COORD_W];
  assign own_colour = colour_in[COL_W*owner_q +: COL_W];
  assign accept     = (state_q == GRANT) && req[owner_q];
  assign next_rr    = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + IDXW'(1);

`ifdef VGA_ARB_CLIP_EN
  // Off-screen pixels are consumed but never written.
  assign pix_ok = ({1'b0, own_coord[14:7]} < 9'(X_MAX)) &&
                  ({1'b0, own_coord[6:0]}  < 8'(Y_MAX));
`else
  assign pix_ok = 1'b1;
`endif

  // Round-robin pick: first pending requester at or above the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDXW'((32'(rr_q) + k) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    coord_d  = coord_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = GRANT;
          grant_d = NREQ'(1) << sel_idx;
          owner_d = sel_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          cnt_d = cnt_q + CNTW'(1);
          if (pix_ok) begin
            we_d     = 1'b1;
            coord_d  = own_coord;
            colour_d = own_colour;
          end
        end
        // Dropped req and the last burst accept are one release, one pointer step.
        if (!accept || (cnt_q == CNTW'(MAX_BURST-1))) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = next_rr;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      coord_q  <= '0;
      colour_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      coord_q  <= coord_d;
      colour_q <= colour_d;
      we_q     <= we_d;
    end
  end

  assign ack              = grant_q & req;
  assign grant            = grant_q;
  assign busy             = busy_q;
  assign coordinates      = coord_q;
  assign colours          = colour_q;
  assign VGA_write_enable = we_q;

endmodule
